// File: rtl/traffic_pkg.sv
// Shared state encodings, lamp patterns and default timing for the traffic light controller.
`timescale 1ns/1ps
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        ALL_RED_B   = 3'd5
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam int DEF_G_MIN   = 4;
    localparam int DEF_G_MAX   = 12;
    localparam int DEF_Y_TICKS = 2;
    localparam int DEF_R_TICKS = 1;
    localparam int DEF_S_TICKS = 6;
    localparam int DEF_CW      = 4;

    // Unknown encodings show red on both roads.
    function automatic logic [2:0] main_lamp(input state_t s);
        case (s)
            MAIN_GREEN:  return GRN;
            MAIN_YELLOW: return YEL;
            default:     return RED;
        endcase
    endfunction

    function automatic logic [2:0] side_lamp(input state_t s);
        case (s)
            SIDE_GREEN:  return GRN;
            SIDE_YELLOW: return YEL;
            default:     return RED;
        endcase
    endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings the divider's slow clock into the fast domain and emits a one-cycle
// registered pulse per rising edge, three cycles after the edge.
`timescale 1ns/1ps
module tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic slow_clk,
    output logic tick
);

    logic sync_p0;
    logic sync_p1;
    logic prev_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            prev_p2 <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync_p0 <= slow_clk;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
            tick    <= sync_p1 & ~prev_p2;
        end
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic light sequencer with pedestrian latch, advanced by ticks
// derived from the slow divider clock; all outputs registered.
`timescale 1ns/1ps
module traffic_light_fsm
    import traffic_pkg::*;
#(
    parameter int G_MIN   = DEF_G_MIN,
    parameter int G_MAX   = DEF_G_MAX,
    parameter int Y_TICKS = DEF_Y_TICKS,
    parameter int R_TICKS = DEF_R_TICKS,
    parameter int S_TICKS = DEF_S_TICKS,
    parameter int CW      = DEF_CW
) (
    input  logic          clkin,
    input  logic          rst_n,
    input  logic          clk_state,
    input  logic          enable,
    input  logic          side_req,
    input  logic          ped_req,
    output logic [2:0]    light_main,
    output logic [2:0]    light_side,
    output logic          ped_walk,
    output logic [CW-1:0] phase_cnt,
    output logic          tick
);

    state_t state;
    state_t next_state;
    state_t succ;
    logic   side_p0, side_p1;
    logic   ped_p0, ped_p1;
    logic   ped_latch;
    logic   adv;
    logic   done;
    logic   legal;
    logic   enter_side;

    tick_sync u_tick_sync (
        .clk      (clkin),
        .rst_n    (rst_n),
        .slow_clk (clk_state),
        .tick     (tick)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            side_p0 <= 1'b0;
            side_p1 <= 1'b0;
            ped_p0  <= 1'b0;
            ped_p1  <= 1'b0;
        end else begin
            side_p0 <= side_req;
            side_p1 <= side_p0;
            ped_p0  <= ped_req;
            ped_p1  <= ped_p0;
        end
    end

    assign adv = tick & enable;

    always_comb begin
        done  = 1'b0;
        succ  = ALL_RED_B;
        legal = 1'b1;
        case (state)
            MAIN_GREEN: begin
                done = (phase_cnt == CW'(G_MAX - 1)) ||
                       ((side_p1 | ped_latch) && (phase_cnt >= CW'(G_MIN - 1)));
                succ = MAIN_YELLOW;
            end
            MAIN_YELLOW: begin
                done = (phase_cnt == CW'(Y_TICKS - 1));
                succ = ALL_RED_A;
            end
            ALL_RED_A: begin
                done = (phase_cnt == CW'(R_TICKS - 1));
                succ = SIDE_GREEN;
            end
            SIDE_GREEN: begin
                done = (phase_cnt == CW'(S_TICKS - 1));
                succ = SIDE_YELLOW;
            end
            SIDE_YELLOW: begin
                done = (phase_cnt == CW'(Y_TICKS - 1));
                succ = ALL_RED_B;
            end
            ALL_RED_B: begin
                done = (phase_cnt == CW'(R_TICKS - 1));
                succ = MAIN_GREEN;
            end
            default: legal = 1'b0;
        endcase

        next_state = state;
        if (!legal) begin
            next_state = ALL_RED_B;
        end else if (adv && done) begin
            next_state = succ;
        end
        enter_side = (next_state == SIDE_GREEN) && (state != SIDE_GREEN);
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ALL_RED_B;
            phase_cnt  <= '0;
            light_main <= RED;
            light_side <= RED;
            ped_walk   <= 1'b0;
            ped_latch  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                phase_cnt <= '0;
            end else if (adv) begin
                phase_cnt <= phase_cnt + CW'(1);
            end
            light_main <= main_lamp(next_state);
            light_side <= side_lamp(next_state);
            // Walk is decided once on entry to side green and held for the whole phase.
            if (enter_side) begin
                ped_walk <= ped_latch;
            end else if (next_state != SIDE_GREEN) begin
                ped_walk <= 1'b0;
            end
            // A fresh request beats the entry clear, so it carries to the next side phase.
            if (ped_p1) begin
                ped_latch <= 1'b1;
            end else if (enter_side) begin
                ped_latch <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm: reset, tick timing, full cycle,
// early exits, pedestrian walk, enable freeze and asynchronous reset.
`timescale 1ns/1ps
module tb_traffic_light_fsm;
    import traffic_pkg::*;

    localparam logic [5:0] GR = {GRN, RED};
    localparam logic [5:0] YR = {YEL, RED};
    localparam logic [5:0] RR = {RED, RED};
    localparam logic [5:0] RG = {RED, GRN};
    localparam logic [5:0] RY = {RED, YEL};

    logic       clkin = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_state = 1'b0;
    logic       enable = 1'b0;
    logic       side_req = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] light_main;
    logic [2:0] light_side;
    logic       ped_walk;
    logic [3:0] phase_cnt;
    logic       tick;

    int n_chk = 0;
    int n_err = 0;
    logic run_mon = 1'b0;

    logic [5:0] full_lamp [24];
    logic [3:0] full_cnt  [24];

    traffic_light_fsm dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .clk_state  (clk_state),
        .enable     (enable),
        .side_req   (side_req),
        .ped_req    (ped_req),
        .light_main (light_main),
        .light_side (light_side),
        .ped_walk   (ped_walk),
        .phase_cnt  (phase_cnt),
        .tick       (tick)
    );

    always #5 clkin = ~clkin;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_phase(input string tag, input logic [5:0] lamps, input logic [3:0] cnt);
        chk({tag, "_lamps"}, 32'({light_main, light_side}), 32'(lamps));
        chk({tag, "_cnt"}, 32'(phase_cnt), 32'(cnt));
    endtask

    // One full clk_state period; the FSM has already reacted when this returns.
    task automatic slow_tick();
        @(posedge clkin); #1 clk_state = 1'b1;
        repeat (4) @(posedge clkin);
        #1 clk_state = 1'b0;
        repeat (4) @(posedge clkin);
        #1;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) slow_tick();
    endtask

    task automatic pulse_ped();
        @(posedge clkin); #1 ped_req = 1'b1;
        @(posedge clkin); #1 ped_req = 1'b0;
        repeat (2) @(posedge clkin);
        #1;
    endtask

    always @(negedge clkin) begin
        if (run_mon) begin
            chk("safety_one_red", 32'((light_main == RED) || (light_side == RED)), 32'd1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        full_lamp = '{GR, GR, GR, GR, GR, GR, GR, GR, GR, GR, GR, YR,
                      YR, RR, RG, RG, RG, RG, RG, RG, RY, RY, RR, GR};
        full_cnt  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0,
                      4'd1, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd0, 4'd0};

        // Reset held while the slow clock toggles.
        repeat (2) @(posedge clkin);
        run_mon = 1'b1;
        repeat (3) begin
            @(posedge clkin); #1 clk_state = 1'b1;
            repeat (3) @(posedge clkin);
            #1 clk_state = 1'b0;
            repeat (3) @(posedge clkin);
        end
        @(negedge clkin);
        expect_phase("reset", RR, 4'd0);
        chk("reset_walk", 32'(ped_walk), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        rst_n  = 1'b1;
        enable = 1'b1;

        // Tick latency: high exactly in cycle t+3, lights follow one cycle later.
        @(posedge clkin); #1 clk_state = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clkin);
            chk($sformatf("tick_c%0d", k), 32'(tick), 32'(k == 3));
            if (k == 3) expect_phase("pre_green", RR, 4'd0);
        end
        expect_phase("first_green", GR, 4'd0);
        clk_state = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clkin);
            chk($sformatf("fall_notick_%0d", k), 32'(tick), 32'd0);
        end

        // Full 24-tick cycle without requests.
        for (int i = 0; i < 24; i++) begin
            slow_tick();
            expect_phase($sformatf("full_t%0d", i + 1), full_lamp[i], full_cnt[i]);
        end

        // side_req present from the start of green: exit held off until G_MIN.
        side_req = 1'b1;
        run_ticks(3);
        expect_phase("early_min_hold", GR, 4'd3);
        slow_tick();
        expect_phase("early_min_exit", YR, 4'd0);
        side_req = 1'b0;
        run_ticks(12);
        expect_phase("early_min_back", GR, 4'd0);

        // side_req raised after G_MIN: exit on the next tick.
        run_ticks(6);
        expect_phase("late_req_green", GR, 4'd6);
        side_req = 1'b1;
        slow_tick();
        expect_phase("late_req_exit", YR, 4'd0);
        side_req = 1'b0;
        run_ticks(12);
        expect_phase("late_req_back", GR, 4'd0);

        // Pedestrian pulse in main green.
        pulse_ped();
        run_ticks(3);
        expect_phase("ped_green", GR, 4'd3);
        chk("ped_walk_off_main", 32'(ped_walk), 32'd0);
        slow_tick();
        expect_phase("ped_exit", YR, 4'd0);
        run_ticks(2);
        expect_phase("ped_allred", RR, 4'd0);
        slow_tick();
        expect_phase("ped_side_in", RG, 4'd0);
        chk("ped_walk_t0", 32'(ped_walk), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) pulse_ped();
            slow_tick();
            expect_phase($sformatf("ped_side_t%0d", k), RG, 4'(k));
            chk($sformatf("ped_walk_t%0d", k), 32'(ped_walk), 32'd1);
        end
        slow_tick();
        expect_phase("ped_side_yel", RY, 4'd0);
        chk("ped_walk_off_yel", 32'(ped_walk), 32'd0);
        run_ticks(3);
        expect_phase("ped_back_main", GR, 4'd0);
        run_ticks(3);
        slow_tick();
        expect_phase("ped2_exit", YR, 4'd0);
        run_ticks(2);
        slow_tick();
        expect_phase("ped2_side_in", RG, 4'd0);
        chk("ped2_walk", 32'(ped_walk), 32'd1);

        // Freeze with enable low, then finish the phase.
        slow_tick();
        expect_phase("frz_before", RG, 4'd1);
        enable = 1'b0;
        run_ticks(5);
        expect_phase("frz_hold", RG, 4'd1);
        chk("frz_walk", 32'(ped_walk), 32'd1);
        enable = 1'b1;
        run_ticks(4);
        expect_phase("frz_resume", RG, 4'd5);
        slow_tick();
        expect_phase("frz_side_yel", RY, 4'd0);

        // Asynchronous reset mid side-yellow drops a pending pedestrian request.
        pulse_ped();
        #3 rst_n = 1'b0;
        #1;
        expect_phase("async_rst", RR, 4'd0);
        chk("async_rst_walk", 32'(ped_walk), 32'd0);
        chk("async_rst_tick", 32'(tick), 32'd0);
        repeat (3) @(posedge clkin);
        @(negedge clkin) rst_n = 1'b1;
        slow_tick();
        expect_phase("rst_green", GR, 4'd0);
        run_ticks(4);
        expect_phase("rst_ped_lost", GR, 4'd4);

        run_mon = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
